iram_loader: RTL and testbench

- Write-side counterpart to the core's instruction-memory read path: receives a program as a stream of 4-bit nibbles on a valid/ready handshake and writes 16-bit words into IRAM at consecutive addresses.
- Holds the core stalled (core_hold) while loading, then releases it with a done flag.
- Sits between the board input pins (datain[3:0]) and the IRAM write port, alongside the control unit.

---
 rtl/iram_loader_pkg.sv | 23 ++
 rtl/iram_loader_if.sv | 32 +++
 rtl/iram_loader_nibble_packer.sv | 31 +++
 rtl/iram_loader.sv | 122 ++++++++++++
 tb/tb_iram_loader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/iram_loader_pkg.sv
// Shared definitions for the IRAM loader: FSM encoding and nibble/word geometry.
package loader_pkg;

  localparam int NIBBLES_PER_WORD = 4;
  localparam int WORD_W           = 16;
  localparam int NIBBLE_W         = WORD_W / NIBBLES_PER_WORD;
  localparam int NIB_CNT_W        = $clog2(NIBBLES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_t;

  // Only the header and payload phases consume nibbles from the pins.
  function automatic logic accepts_nibbles(input loader_state_t s);
    return (s == HDR) || (s == LOAD);
  endfunction

endpackage

// File: rtl/iram_loader_if.sv
// Nibble input stream plus IRAM write port, bundled for the loader and its environment.
interface iram_loader_if #(
  parameter int ADDR_W = 16
);
  import loader_pkg::*;

  logic [NIBBLE_W-1:0] datain;
  logic                din_valid;
  logic                din_ready;
  logic                mem_write_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_dataout;

  modport slave (
    input  datain,
    input  din_valid,
    output din_ready,
    output mem_write_en,
    output mem_addr,
    output mem_dataout
  );

  modport master (
    output datain,
    output din_valid,
    input  din_ready,
    input  mem_write_en,
    input  mem_addr,
    input  mem_dataout
  );

endinterface

// File: rtl/iram_loader_nibble_packer.sv
// Assembles MSB-first nibbles into words; word_complete fires combinationally on the
// accept that delivers the last nibble so the word is usable on that same edge.
module nibble_packer
  import loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                accept,
  input  logic [NIBBLE_W-1:0] datain,
  output logic [WORD_W-1:0]   word,
  output logic                word_complete
);

  // Only the three older nibbles need storing; the newest one comes straight from datain.
  logic [WORD_W-NIBBLE_W-1:0] sh;
  logic [NIB_CNT_W-1:0]       cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sh  <= {sh[WORD_W-2*NIBBLE_W-1:0], datain};
      cnt <= cnt + 1'b1;
    end
  end

  assign word          = {sh, datain};
  assign word_complete = accept && (cnt == NIB_CNT_W'(NIBBLES_PER_WORD - 1));

endmodule

// File: rtl/iram_loader.sv
// Streams a length-prefixed program from the nibble pins into IRAM while holding the core.
module iram_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  iram_loader_if.slave   bus,
  output logic           core_hold,
  output logic           done,
  output logic           error
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       DEPTH_U = DEPTH;

  loader_state_t     state, state_n;
  logic [WORD_W-1:0] word;
  logic              word_complete;
  logic              accept;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [15:0]       word_cnt_inc;
  logic              last_word;
  logic              len_zero;
  logic              len_over;

  assign bus.din_ready    = accepts_nibbles(state);
  assign bus.mem_write_en = (state == WRITE);
  assign accept           = bus.din_valid && bus.din_ready;

  assign word_cnt_inc = word_cnt + 16'd1;
  assign last_word    = (word_cnt_inc == len);
  assign len_zero     = (word == '0);
  assign len_over     = ({16'd0, word} > DEPTH_U);

  nibble_packer u_packer (
    .clk           (clk),
    .reset_n       (reset_n),
    .accept        (accept),
    .datain        (bus.datain),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = HDR;
      HDR: begin
        if (word_complete) begin
          if (len_zero)      state_n = DONE;
          else if (len_over) state_n = ERR;
          else               state_n = LOAD;
        end
      end
      LOAD:  if (word_complete) state_n = WRITE;
      WRITE: state_n = last_word ? DONE : LOAD;
      DONE:  if (start) state_n = HDR;
      ERR:   if (start) state_n = HDR;
      default: state_n = IDLE;
    endcase
  end

  // Status flags, counters and the write port; start only matters outside a session.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_hold       <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      len             <= '0;
      word_cnt        <= '0;
      bus.mem_addr    <= BASE;
      bus.mem_dataout <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
          end
        end
        HDR: begin
          if (word_complete) begin
            len          <= word;
            word_cnt     <= '0;
            bus.mem_addr <= BASE;
            if (len_zero) begin
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else if (len_over) begin
              error     <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_complete) bus.mem_dataout <= word;
        end
        WRITE: begin
          word_cnt     <= word_cnt_inc;
          bus.mem_addr <= bus.mem_addr + 1'b1;
          if (last_word) begin
            done      <= 1'b1;
            core_hold <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// Directed-plus-random bench for iram_loader: drives nibble programs and compares the
// captured IRAM writes against the program contents.
module tb_iram_loader;

  localparam int ADDR_W    = 16;
  localparam int DEPTH     = 256;
  localparam int BASE_ADDR = 0;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic core_hold, done, error;

  int tests    = 0;
  int failures = 0;

  iram_loader_if #(.ADDR_W(ADDR_W)) bus ();

  iram_loader #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bus       (bus),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Write monitor: records every strobe, its latency from the last accepted nibble,
  // and whether din_ready was wrongly high during it.
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          wr_lat_q[$];
  int          wr_cyc_q[$];
  int          cyc        = 0;
  int          last_acc   = 0;
  int          ready_viol = 0;

  always @(posedge clk) begin
    if (reset_n && bus.din_valid && bus.din_ready) last_acc <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset_n && bus.mem_write_en) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_dataout);
      wr_lat_q.push_back(cyc - last_acc);
      wr_cyc_q.push_back(cyc);
      if (bus.din_ready) ready_viol <= ready_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_lat_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start         = 1'b1;
    bus.din_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] n, input int max_gap);
    int t;
    repeat ($urandom_range(max_gap, 0)) begin
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.datain    = 4'($urandom);
    end
    @(negedge clk);
    bus.din_valid = 1'b1;
    bus.datain    = n;
    t = 0;
    while (!bus.din_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("handshake_timeout", 32'(t), 32'd0);
  endtask

  task automatic send_word(input logic [15:0] w, input int max_gap);
    for (int k = 3; k >= 0; k--) send_nibble(w[4*k +: 4], max_gap);
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int t = 0;
    while (!(done || error) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) check("wait_end_timeout", 32'(t), 32'(budget - 1));
  endtask

  task automatic send_program(input logic [15:0] words[$], input int max_gap);
    send_word(16'(words.size()), max_gap);
    foreach (words[i]) send_word(words[i], max_gap);
    end_stream();
  endtask

  // Reference: word i of the program lands at BASE_ADDR+i, in order, exactly once.
  task automatic check_writes(input string tag, input logic [15:0] words[$]);
    logic [15:0] a, d;
    check({tag, "_count"}, 32'(wr_addr_q.size()), 32'(words.size()));
    foreach (words[i]) begin
      a = (i < wr_addr_q.size()) ? wr_addr_q[i] : 16'hxxxx;
      d = (i < wr_data_q.size()) ? wr_data_q[i] : 16'hxxxx;
      check($sformatf("%s_addr%0d", tag, i), 32'(a), 32'(BASE_ADDR + i));
      check($sformatf("%s_data%0d", tag, i), 32'(d), 32'(words[i]));
    end
  endtask

  function automatic void random_words(output logic [15:0] q[$], input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(16'($urandom));
  endfunction

  initial begin
    logic [15:0] prog[$];

    reset_n       = 1'b0;
    start         = 1'b0;
    bus.din_valid = 1'b0;
    bus.datain    = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_core_hold", 32'(core_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_write_en", 32'(bus.mem_write_en), 32'd0);
    check("rst_din_ready", 32'(bus.din_ready), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'(BASE_ADDR));
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic two-word load");
    clear_log();
    pulse_start();
    check("basic_hold_on", 32'(core_hold), 32'd1);
    check("basic_ready_hdr", 32'(bus.din_ready), 32'd1);
    prog = '{16'h1234, 16'hABCD};
    send_program(prog, 0);
    wait_end(50);
    check_writes("basic", prog);
    check("basic_done", 32'(done), 32'd1);
    check("basic_hold_off", 32'(core_hold), 32'd0);
    check("basic_error", 32'(error), 32'd0);
    if (wr_cyc_q.size() == 2) check("basic_throughput", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd5);
    repeat (10) @(negedge clk);
    check("basic_no_extra", 32'(wr_addr_q.size()), 32'd2);

    $display("[TB] zero-length program");
    clear_log();
    pulse_start();
    check("zero_hold_on", 32'(core_hold), 32'd1);
    check("zero_done_cleared", 32'(done), 32'd0);
    prog.delete();
    send_program(prog, 1);
    wait_end(50);
    check("zero_done", 32'(done), 32'd1);
    check("zero_hold_off", 32'(core_hold), 32'd0);
    check("zero_writes", 32'(wr_addr_q.size()), 32'd0);

    $display("[TB] oversize header then recovery");
    clear_log();
    pulse_start();
    send_word(16'h0101, 0);
    end_stream();
    wait_end(50);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_hold", 32'(core_hold), 32'd1);
    check("ovf_done", 32'(done), 32'd0);
    check("ovf_ready", 32'(bus.din_ready), 32'd0);
    repeat (5) @(negedge clk);
    check("ovf_writes", 32'(wr_addr_q.size()), 32'd0);
    pulse_start();
    check("ovf_error_cleared", 32'(error), 32'd0);
    prog = '{16'h00FF};
    send_program(prog, 0);
    wait_end(50);
    check_writes("recover", prog);
    check("recover_done", 32'(done), 32'd1);
    check("recover_error", 32'(error), 32'd0);

    $display("[TB] full-depth program");
    clear_log();
    pulse_start();
    random_words(prog, DEPTH);
    send_program(prog, 0);
    wait_end(2000);
    check_writes("full", prog);
    check("full_done", 32'(done), 32'd1);

    $display("[TB] random handshake gaps");
    clear_log();
    pulse_start();
    random_words(prog, 16);
    send_program(prog, 3);
    wait_end(500);
    check_writes("stall", prog);
    check("stall_ready_in_write", 32'(ready_viol), 32'd0);
    foreach (wr_lat_q[i]) check($sformatf("stall_latency%0d", i), 32'(wr_lat_q[i]), 32'd1);

    $display("[TB] start pulsed during load");
    clear_log();
    pulse_start();
    random_words(prog, 4);
    send_word(16'd4, 0);
    send_word(prog[0], 0);
    send_word(prog[1], 0);
    pulse_start();
    check("midstart_hold", 32'(core_hold), 32'd1);
    check("midstart_done", 32'(done), 32'd0);
    send_word(prog[2], 1);
    send_word(prog[3], 1);
    end_stream();
    wait_end(100);
    check_writes("midstart", prog);
    check("midstart_done_end", 32'(done), 32'd1);

    $display("[TB] reset mid-word");
    clear_log();
    pulse_start();
    send_word(16'd3, 0);
    send_word(16'h1111, 0);
    send_nibble(4'h2, 0);
    send_nibble(4'h2, 0);
    @(negedge clk);
    bus.din_valid = 1'b0;
    reset_n       = 1'b0;
    #1;
    check("midrst_core_hold", 32'(core_hold), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_write_en", 32'(bus.mem_write_en), 32'd0);
    check("midrst_din_ready", 32'(bus.din_ready), 32'd0);
    check("midrst_mem_addr", 32'(bus.mem_addr), 32'(BASE_ADDR));
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    pulse_start();
    random_words(prog, 2);
    send_program(prog, 1);
    wait_end(100);
    check_writes("postrst", prog);
    check("postrst_done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
